mmio_bus_ctrl: RTL and testbench

MMIO_BUS_CTRL -- requirements
Module: mmio_bus_ctrl

---
 rtl/mmio_bus_ctrl_if.sv | 11 +
 rtl/mmio_bus_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_mmio_bus_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_bus_ctrl_if.sv
// CPU data-side load/store bus between the core (master) and the MMIO controller (slave).
interface mmio_bus_ctrl_if;
  logic [31:0] data_addr;
  logic [31:0] data_write;
  logic [2:0]  MemOp;
  logic        MemWe;
  logic [31:0] data_read;

  modport master (output data_addr, data_write, MemOp, MemWe, input data_read);
  modport slave  (input data_addr, data_write, MemOp, MemWe, output data_read);
endinterface

// File: rtl/mmio_bus_ctrl.sv
// MMIO bus controller: routes CPU loads/stores to data RAM, VGA text RAM, keyboard FIFO, LEDs, switches, hex display.
// Define MMIO_TIMER_EN to build the free-running 32-bit cycle timer at the TIMER region.
module mmio_bus_ctrl #(
  parameter int KBD_DEPTH = 16
) (
  input  logic                  clock,
  input  logic                  resetn,
  mmio_bus_ctrl_if.slave        bus,
  output logic [31:0]           dmem_addr,
  output logic [31:0]           dmem_wdata,
  output logic [3:0]            dmem_be,
  output logic                  dmem_we,
  input  logic [31:0]           dmem_rdata,
  output logic [11:0]           vga_addr,
  output logic [7:0]            vga_wdata,
  output logic                  vga_we,
  input  logic                  kbd_valid,
  input  logic [7:0]            kbd_code,
  input  logic [15:0]           sw_in,
  output logic [15:0]           led_out,
  output logic [31:0]           hex_out
);
  localparam int PW = $clog2(KBD_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    RG_NONE, RG_DMEM, RG_VGA, RG_KBD, RG_LED, RG_SW, RG_HEX, RG_TIMER
  } region_t;

  region_t       region, region_reg;
  logic [1:0]    size;
  logic [1:0]    addr_lo_reg;
  logic [2:0]    op_reg;
  logic [31:0]   mmio_word, mmio_word_reg;
  logic          pop_hit_reg;
  logic [7:0]    kbd_head_reg;
  logic [7:0]    kbd_mem [KBD_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic          ovf_reg, ovf_next;
  logic          store, load;
  logic          kbd_data_sel, kbd_stat_sel;
  logic          fifo_empty, fifo_full, pop_ok, push_ok;
  logic [31:0]   timer_word, src_word;
  logic [7:0]    load_byte;
  logic [15:0]   load_half;

  always_comb begin
    case (bus.data_addr[31:20])
      12'h001: region = RG_DMEM;
      12'h002: region = RG_VGA;
      12'h003: region = RG_KBD;
      12'h004: region = RG_LED;
      12'h005: region = RG_SW;
      12'h006: region = RG_HEX;
      12'h007: region = RG_TIMER;
      default: region = RG_NONE;
    endcase
  end

  assign store = bus.MemWe & resetn;
  assign load  = ~bus.MemWe & resetn;
  assign size  = bus.MemOp[1:0];

  // Byte lanes: enable and replicated store data per lane
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign dmem_be[gi] = (size == 2'b00) ? (bus.data_addr[1:0] == 2'(gi)) :
                           (size == 2'b01) ? (bus.data_addr[1] == 1'(gi / 2)) : 1'b1;
      assign dmem_wdata[8*gi +: 8] = (size == 2'b00) ? bus.data_write[7:0] :
                                     (size == 2'b01) ? bus.data_write[8*(gi % 2) +: 8] :
                                                       bus.data_write[8*gi +: 8];
    end
  endgenerate

  assign dmem_addr = bus.data_addr;
  assign dmem_we   = store & (region == RG_DMEM);
  assign vga_addr  = bus.data_addr[11:0];
  assign vga_wdata = bus.data_write[7:0];
  assign vga_we    = store & (region == RG_VGA);

  assign kbd_data_sel = (region == RG_KBD) && (bus.data_addr[19:0] == 20'h0_0000);
  assign kbd_stat_sel = (region == RG_KBD) && (bus.data_addr[19:0] == 20'h0_0004);
  assign fifo_empty   = (count_reg == '0);
  assign fifo_full    = (count_reg == CW'(KBD_DEPTH));
  assign pop_ok       = load & kbd_data_sel & ~fifo_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign push_ok      = kbd_valid & resetn & (~fifo_full | pop_ok);

  always_comb begin
    count_next = count_reg;
    if (push_ok && !pop_ok)
      count_next = count_reg + CW'(1);
    else if (pop_ok && !push_ok)
      count_next = count_reg - CW'(1);
    ovf_next = ovf_reg;
    if (store && kbd_stat_sel)
      ovf_next = 1'b0;
    if (kbd_valid && !push_ok)
      ovf_next = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (push_ok)
      kbd_mem[wr_ptr_reg] <= kbd_code;
    kbd_head_reg <= kbd_mem[rd_ptr_reg];
  end

`ifdef MMIO_TIMER_EN
  logic [31:0] timer_reg;

  always_ff @(posedge clock) begin
    if (!resetn)
      timer_reg <= '0;
    else if (store && region == RG_TIMER)
      timer_reg <= bus.data_write;
    else
      timer_reg <= timer_reg + 32'd1;
  end

  assign timer_word = timer_reg;
`else
  assign timer_word = '0;
`endif

  always_comb begin
    mmio_word = '0;
    case (region)
      RG_KBD:   if (kbd_stat_sel) mmio_word = {23'b0, ovf_reg, 8'(count_reg)};
      RG_LED:   mmio_word = {16'b0, led_out};
      RG_SW:    mmio_word = {16'b0, sw_in};
      RG_HEX:   mmio_word = hex_out;
      RG_TIMER: mmio_word = timer_word;
      default:  mmio_word = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      ovf_reg       <= 1'b0;
      region_reg    <= RG_NONE;
      addr_lo_reg   <= 2'b00;
      op_reg        <= 3'b000;
      mmio_word_reg <= '0;
      pop_hit_reg   <= 1'b0;
      led_out       <= '0;
      hex_out       <= '0;
    end else begin
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop_ok)
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
      if (store && region == RG_LED)
        led_out <= bus.data_write[15:0];
      if (store && region == RG_HEX)
        hex_out <= bus.data_write;
      // A store cycle ends the previous load's result and reads back as zero
      region_reg    <= load ? region : RG_NONE;
      addr_lo_reg   <= bus.data_addr[1:0];
      op_reg        <= bus.MemOp;
      mmio_word_reg <= load ? mmio_word : '0;
      pop_hit_reg   <= pop_ok;
    end
  end

  assign src_word  = (region_reg == RG_DMEM) ? dmem_rdata :
                     pop_hit_reg ? {24'b0, kbd_head_reg} : mmio_word_reg;
  assign load_byte = src_word[{addr_lo_reg, 3'b000} +: 8];
  assign load_half = addr_lo_reg[1] ? src_word[31:16] : src_word[15:0];

  always_comb begin
    case (op_reg)
      3'b000:  bus.data_read = {{24{load_byte[7]}}, load_byte};
      3'b001:  bus.data_read = {{16{load_half[15]}}, load_half};
      3'b100:  bus.data_read = {24'b0, load_byte};
      3'b101:  bus.data_read = {16'b0, load_half};
      default: bus.data_read = src_word;
    endcase
  end
endmodule

// File: tb/tb_mmio_bus_ctrl.sv
// Randomized self-checking bench for mmio_bus_ctrl against a queue/array reference model.
module tb_mmio_bus_ctrl;
  localparam int DEPTH = 16;
  localparam logic [31:0] A_DMEM = 32'h0010_0000;
  localparam logic [31:0] A_VGA  = 32'h0020_0000;
  localparam logic [31:0] A_KBD  = 32'h0030_0000;
  localparam logic [31:0] A_KST  = 32'h0030_0004;
  localparam logic [31:0] A_LED  = 32'h0040_0000;
  localparam logic [31:0] A_SW   = 32'h0050_0000;
  localparam logic [31:0] A_HEX  = 32'h0060_0000;
  localparam logic [31:0] A_TMR  = 32'h0070_0000;

  logic        clock = 1'b0;
  logic        resetn;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        dmem_we;
  logic [11:0] vga_addr;
  logic [7:0]  vga_wdata;
  logic        vga_we;
  logic        kbd_valid;
  logic [7:0]  kbd_code;
  logic [15:0] sw_in, led_out;
  logic [31:0] hex_out;

  mmio_bus_ctrl_if bus ();

  mmio_bus_ctrl #(.KBD_DEPTH(DEPTH)) dut (
    .clock(clock), .resetn(resetn), .bus(bus),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_we(dmem_we),
    .dmem_rdata(dmem_rdata),
    .vga_addr(vga_addr), .vga_wdata(vga_wdata), .vga_we(vga_we),
    .kbd_valid(kbd_valid), .kbd_code(kbd_code),
    .sw_in(sw_in), .led_out(led_out), .hex_out(hex_out)
  );

  always #5 clock = ~clock;

  // Data RAM attached to the DUT: synchronous 1-cycle read, byte-enabled write
  logic [31:0] ram [256];
  always @(posedge clock) begin
    for (int b = 0; b < 4; b++)
      if (dmem_we && dmem_be[b])
        ram[dmem_addr[9:2]][8*b +: 8] <= dmem_wdata[8*b +: 8];
    dmem_rdata <= ram[dmem_addr[9:2]];
  end

  // Reference model state
  logic [31:0] m_mem [256];
  logic [7:0]  m_q [$];
  logic        m_ovf;
  logic [15:0] m_led;
  logic [31:0] m_hex;
  logic [31:0] m_timer;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] lo, input logic [2:0] op);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * lo));
    h = 16'(w >> (16 * lo[1]));
    case (op)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  task automatic do_cycle(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] op,
                          input logic we, input logic kv, input logic [7:0] kc);
    logic [11:0] rg;
    logic [1:0]  sz;
    logic [31:0] word, exp_rd, exp_wd;
    logic [3:0]  exp_be;
    bit          sel;
    bus.data_addr = a; bus.data_write = wd; bus.MemOp = op; bus.MemWe = we;
    kbd_valid = kv; kbd_code = kc;
    #1;
    rg = a[31:20];
    sz = op[1:0];
    check("dmem_we", dmem_we, we && rg == 12'h001);
    check("vga_we", vga_we, we && rg == 12'h002);
    if (we && rg == 12'h001) begin
      exp_wd = (sz == 2'b00) ? {4{wd[7:0]}} : (sz == 2'b01) ? {2{wd[15:0]}} : wd;
      exp_be = 4'b0000;
      for (int b = 0; b < 4; b++) begin
        sel = (sz == 2'b00) ? (b == int'(a[1:0])) : (sz == 2'b01) ? ((b / 2) == int'(a[1])) : 1'b1;
        if (sel) begin
          exp_be[b] = 1'b1;
          m_mem[a[9:2]][8*b +: 8] = exp_wd[8*b +: 8];
        end
      end
      check("dmem_be", dmem_be, exp_be);
      check("dmem_wdata", dmem_wdata, exp_wd);
    end
    if (we && rg == 12'h002) begin
      check("vga_addr", vga_addr, a[11:0]);
      check("vga_wdata", vga_wdata, wd[7:0]);
    end
    exp_rd = '0;
    word   = '0;
    if (we) begin
      if (rg == 12'h004) m_led = wd[15:0];
      if (rg == 12'h006) m_hex = wd;
      if (rg == 12'h003 && a[19:0] == 20'h4) m_ovf = 1'b0;
    end else begin
      case (rg)
        12'h001: word = m_mem[a[9:2]];
        12'h003: begin
          if (a[19:0] == 20'h0 && m_q.size() > 0) word = {24'b0, m_q.pop_front()};
          else if (a[19:0] == 20'h4) word = {23'b0, m_ovf, 8'(m_q.size())};
        end
        12'h004: word = {16'b0, m_led};
        12'h005: word = {16'b0, sw_in};
        12'h006: word = m_hex;
`ifdef MMIO_TIMER_EN
        12'h007: word = m_timer;
`endif
        default: word = '0;
      endcase
      exp_rd = extend(word, a[1:0], op);
    end
    if (kv) begin
      if (m_q.size() < DEPTH) m_q.push_back(kc);
      else m_ovf = 1'b1;
    end
    if (we && rg == 12'h007) m_timer = wd;
    else m_timer = m_timer + 32'd1;
    @(posedge clock);
    @(negedge clock);
    $display("cyc a=%h wd=%h op=%0d we=%0b kv=%0b rd=%h", a, wd, op, we, kv, bus.data_read);
    check("data_read", bus.data_read, exp_rd);
    check("led_out", led_out, m_led);
    check("hex_out", hex_out, m_hex);
  endtask

  task automatic idle(input logic kv, input logic [7:0] kc);
    do_cycle(32'h0, 32'h0, 3'b010, 1'b0, kv, kc);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    bus.data_addr = A_DMEM; bus.data_write = 32'hFFFF_FFFF; bus.MemOp = 3'b010; bus.MemWe = 1'b1;
    kbd_valid = 1'b1; kbd_code = 8'h99;
    #1;
    check("rst_dmem_we", dmem_we, 1'b0);
    @(posedge clock);
    @(negedge clock);
    bus.data_addr = A_VGA;
    #1;
    check("rst_vga_we", vga_we, 1'b0);
    @(posedge clock);
    @(negedge clock);
    $display("reset applied");
    check("rst_data_read", bus.data_read, 32'h0);
    check("rst_led", led_out, 16'h0);
    check("rst_hex", hex_out, 32'h0);
    bus.MemWe = 1'b0; bus.data_addr = 32'h0; kbd_valid = 1'b0;
    m_q.delete();
    m_ovf = 1'b0; m_led = '0; m_hex = '0; m_timer = '0;
    resetn = 1'b1;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0, 1:    return A_DMEM | 32'($urandom_range(0, 1023));
      2:       return A_VGA | 32'($urandom_range(0, 4095));
      3, 4:    return A_KBD | 32'(4 * $urandom_range(0, 2));
      5:       return A_LED | 32'($urandom_range(0, 3));
      6:       return A_SW | 32'($urandom_range(0, 3));
      7:       return A_HEX | 32'($urandom_range(0, 3));
      8:       return A_TMR;
      default: return ($urandom_range(0, 1) == 1) ? 32'h0080_0010 : 32'hFFF0_0000;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] ops [5];
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010; ops[3] = 3'b100; ops[4] = 3'b101;
    for (int i = 0; i < 256; i++) begin
      ram[i]   = $urandom;
      m_mem[i] = ram[i];
    end
    sw_in = 16'h0;
    do_reset();

    // Byte store, then signed and unsigned byte loads
    do_cycle(32'h0010_0003, 32'h0000_00A5, 3'b000, 1'b1, 1'b0, 8'h0);
    check("sb_be", dmem_be, 4'b1000);
    check("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
    do_cycle(32'h0010_0003, 32'h0, 3'b000, 1'b0, 1'b0, 8'h0);
    check("lb", bus.data_read, 32'hFFFF_FFA5);
    do_cycle(32'h0010_0003, 32'h0, 3'b100, 1'b0, 1'b0, 8'h0);
    check("lbu", bus.data_read, 32'h0000_00A5);

    // Two codes, status, then in-order pops and empty pop
    idle(1'b1, 8'h1C);
    idle(1'b1, 8'h32);
    do_cycle(A_KST, 32'h0, 3'b010, 1'b0, 1'b0, 8'h0);
    check("kbd_cnt2", bus.data_read, 32'h2);
    do_cycle(A_KBD, 32'h0, 3'b010, 1'b0, 1'b0, 8'h0);
    check("kbd_pop1", bus.data_read, 32'h1C);
    do_cycle(A_KBD, 32'h0, 3'b010, 1'b0, 1'b0, 8'h0);
    check("kbd_pop2", bus.data_read, 32'h32);
    do_cycle(A_KBD, 32'h0, 3'b010, 1'b0, 1'b0, 8'h0);
    check("kbd_pop_empty", bus.data_read, 32'h0);
    do_cycle(A_KST, 32'h0, 3'b010, 1'b0, 1'b0, 8'h0);
    check("kbd_cnt0", bus.data_read, 32'h0);

    // Overflow on the 17th push, cleared by a status store
    for (int i = 0; i < 17; i++) idle(1'b1, 8'(8'h40 + i));
    do_cycle(A_KST, 32'h0, 3'b010, 1'b0, 1'b0, 8'h0);
    check("kbd_ovf", bus.data_read, 32'h110);
    do_cycle(A_KST, 32'h0, 3'b010, 1'b1, 1'b0, 8'h0);
    do_cycle(A_KST, 32'h0, 3'b010, 1'b0, 1'b0, 8'h0);
    check("kbd_ovf_clr", bus.data_read, 32'h010);
    do_cycle(A_KBD, 32'h0, 3'b010, 1'b0, 1'b0, 8'h0);
    check("kbd_first", bus.data_read, 32'h40);
    for (int i = 0; i < 15; i++) do_cycle(A_KBD, 32'h0, 3'b010, 1'b0, 1'b0, 8'h0);

    // Pop and push in the same cycle keeps count and order
    idle(1'b1, 8'h11);
    idle(1'b1, 8'h22);
    idle(1'b1, 8'h33);
    do_cycle(A_KBD, 32'h0, 3'b010, 1'b0, 1'b1, 8'h44);
    check("kbd_pp_pop", bus.data_read, 32'h11);
    do_cycle(A_KST, 32'h0, 3'b010, 1'b0, 1'b0, 8'h0);
    check("kbd_pp_cnt", bus.data_read, 32'h3);
    do_cycle(A_KBD, 32'h0, 3'b010, 1'b0, 1'b0, 8'h0);
    check("kbd_pp_22", bus.data_read, 32'h22);
    do_cycle(A_KBD, 32'h0, 3'b010, 1'b0, 1'b0, 8'h0);
    check("kbd_pp_33", bus.data_read, 32'h33);
    do_cycle(A_KBD, 32'h0, 3'b010, 1'b0, 1'b0, 8'h0);
    check("kbd_pp_44", bus.data_read, 32'h44);

    // HEX/LED stores, switch readback, then reset clears everything
    do_cycle(A_HEX, 32'h1234_5678, 3'b010, 1'b1, 1'b0, 8'h0);
    do_cycle(A_LED, 32'h0000_BEEF, 3'b001, 1'b1, 1'b0, 8'h0);
    sw_in = 16'h00F0;
    do_cycle(A_SW, 32'h0, 3'b010, 1'b0, 1'b0, 8'h0);
    check("sw_load", bus.data_read, 32'h0000_00F0);
    check("hex_val", hex_out, 32'h1234_5678);
    check("led_val", led_out, 16'hBEEF);
    do_reset();
    idle(1'b0, 8'h0);

    // Timer: store 100, read back after five idle cycles
    do_cycle(A_TMR, 32'd100, 3'b010, 1'b1, 1'b0, 8'h0);
    for (int i = 0; i < 5; i++) idle(1'b0, 8'h0);
    do_cycle(A_TMR, 32'h0, 3'b010, 1'b0, 1'b0, 8'h0);
`ifdef MMIO_TIMER_EN
    check("timer", bus.data_read, 32'd105);
`else
    check("timer", bus.data_read, 32'd0);
`endif

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) sw_in = 16'($urandom);
      if ($urandom_range(0, 299) == 0) do_reset();
      do_cycle(rand_addr(), $urandom, ops[$urandom_range(0, 4)],
               ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 3), 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
